// File: rtl/ucie_ig_buf.sv
// ---------------------------------------------------------------------------
// ucie_ig_buf -- ingress pattern replay buffer for the UCIe test datapath.
//
// Software loads 32-bit words one at a time (rising edge of i_ig_wdata_upd
// while i_ig_wdata_en is high). A programmed inclusive pointer range is then
// replayed toward the TX serializer as a valid/ready stream, either once or
// in loops. Reads never consume entries.
//
// Optional feature macro: UCIE_IG_OVF_WRAP_EN
//   defined     : a write while full overwrites mem[wr_ptr] and advances wr_ptr
//   not defined : a write while full is discarded
//   Either way the sticky overflow flag sets.
//
// Ports:
//   i_hclk, i_hresetn          clock, asynchronous active-low reset
//   i_ig_loop_mode             0 single pass, 1 loop
//   i_ig_num_loops[3:0]        passes in loop mode, 0 = infinite
//   i_ig_load_ptr              rising edge starts playback, low aborts
//   i_ig_start_ptr/stop_ptr    inclusive playback range
//   i_ig_wdata_clr             level clear of write side and playback
//   i_ig_wdata_hold            level gate on o_tx_valid
//   i_ig_wdata_en/upd/wdata    write enable, write strobe (edge), write data
//   o_ig_empty/full            occupancy status
//   o_ig_write_done            sticky: a write landed at stop_ptr
//   o_ig_overflow              sticky: a write arrived while full
//   o_tx_valid/o_tx_data       playback stream, i_tx_ready downstream accept
// ---------------------------------------------------------------------------
module ucie_ig_buf #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              i_hclk,
    input  logic              i_hresetn,
    input  logic              i_ig_loop_mode,
    input  logic [3:0]        i_ig_num_loops,
    input  logic              i_ig_load_ptr,
    input  logic [PTR_W-1:0]  i_ig_start_ptr,
    input  logic [PTR_W-1:0]  i_ig_stop_ptr,
    input  logic              i_ig_wdata_clr,
    input  logic              i_ig_wdata_hold,
    input  logic              i_ig_wdata_en,
    input  logic              i_ig_wdata_upd,
    input  logic [DWIDTH-1:0] i_ig_wdata,
    output logic              o_ig_empty,
    output logic              o_ig_full,
    output logic              o_ig_write_done,
    output logic              o_ig_overflow,
    output logic              o_tx_valid,
    output logic [DWIDTH-1:0] o_tx_data,
    input  logic              i_tx_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [DWIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [3:0]        pass_cnt_reg;
    logic              upd_q_reg;
    logic              load_q_reg;
    logic              overflow_reg;
    logic              write_done_reg;

    logic              full;
    logic              wr_fire;
    logic              mem_we;
    logic              load_rise;
    logic              beat;
    logic              last_pass;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [DEPTH-1:0]  we_vec;

    assign full      = (count_reg == (PTR_W+1)'(DEPTH));
    // Clear has priority, so a write in a clear cycle is simply not fired.
    assign wr_fire   = i_ig_wdata_upd && !upd_q_reg && i_ig_wdata_en && !i_ig_wdata_clr;
`ifdef UCIE_IG_OVF_WRAP_EN
    assign mem_we    = wr_fire;
`else
    assign mem_we    = wr_fire && !full;
`endif
    assign load_rise = i_ig_load_ptr && !load_q_reg;
    assign beat      = o_tx_valid && i_tx_ready;
    // Widened compare so pass_cnt+1 cannot alias back to a small num_loops.
    assign last_pass = (i_ig_num_loops != 4'd0) &&
                       (({1'b0, pass_cnt_reg} + 5'd1) == {1'b0, i_ig_num_loops});

    assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_inc  = (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;

    // One-hot write enable per entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we_vec[gi] = mem_we && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    mem_reg[i] <= i_ig_wdata;
                end
            end
        end
    end

    // Write side: pointers, occupancy and sticky status.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            upd_q_reg      <= 1'b0;
            load_q_reg     <= 1'b0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            write_done_reg <= 1'b0;
        end else begin
            upd_q_reg  <= i_ig_wdata_upd;
            load_q_reg <= i_ig_load_ptr;
            if (i_ig_wdata_clr) begin
                wr_ptr_reg     <= '0;
                count_reg      <= '0;
                overflow_reg   <= 1'b0;
                write_done_reg <= 1'b0;
            end else if (wr_fire) begin
                if (full) begin
                    overflow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
                if (mem_we) begin
                    wr_ptr_reg <= wr_ptr_next;
                    if (wr_ptr_reg == i_ig_stop_ptr) begin
                        write_done_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // Playback FSM.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            state_reg    <= ST_IDLE;
            rd_ptr_reg   <= '0;
            pass_cnt_reg <= '0;
        end else if (i_ig_wdata_clr) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_rise && (count_reg != '0)) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rd_ptr_reg   <= i_ig_start_ptr;
                    pass_cnt_reg <= '0;
                    state_reg    <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (!i_ig_load_ptr) begin
                        state_reg <= ST_IDLE;
                    end else if (beat) begin
                        if (rd_ptr_reg != i_ig_stop_ptr) begin
                            rd_ptr_reg <= rd_ptr_inc;
                        end else begin
                            pass_cnt_reg <= pass_cnt_reg + 1'b1;
                            if (!i_ig_loop_mode || last_pass) begin
                                state_reg <= ST_DONE;
                            end else begin
                                rd_ptr_reg <= i_ig_start_ptr;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (load_rise) begin
                        state_reg <= ST_LOAD;
                    end else if (!i_ig_load_ptr) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Hold gates valid live so a beat can be withdrawn mid-cycle.
    assign o_tx_valid      = (state_reg == ST_PLAY) && !i_ig_wdata_hold;
    assign o_tx_data       = mem_reg[rd_ptr_reg];
    assign o_ig_empty      = (count_reg == '0);
    assign o_ig_full       = full;
    assign o_ig_overflow   = overflow_reg;
    assign o_ig_write_done = write_done_reg;

endmodule

// File: tb/tb_ucie_ig_buf.sv
module tb_ucie_ig_buf;

    logic        i_hclk = 1'b0;
    logic        i_hresetn;
    logic        i_ig_loop_mode;
    logic [3:0]  i_ig_num_loops;
    logic        i_ig_load_ptr;
    logic [4:0]  i_ig_start_ptr;
    logic [4:0]  i_ig_stop_ptr;
    logic        i_ig_wdata_clr;
    logic        i_ig_wdata_hold;
    logic        i_ig_wdata_en;
    logic        i_ig_wdata_upd;
    logic [31:0] i_ig_wdata;
    logic        o_ig_empty;
    logic        o_ig_full;
    logic        o_ig_write_done;
    logic        o_ig_overflow;
    logic        o_tx_valid;
    logic [31:0] o_tx_data;
    logic        i_tx_ready;

    int errors = 0;
    int checks = 0;

    ucie_ig_buf #(.DWIDTH(32), .DEPTH(32)) dut (
        .i_hclk          (i_hclk),
        .i_hresetn       (i_hresetn),
        .i_ig_loop_mode  (i_ig_loop_mode),
        .i_ig_num_loops  (i_ig_num_loops),
        .i_ig_load_ptr   (i_ig_load_ptr),
        .i_ig_start_ptr  (i_ig_start_ptr),
        .i_ig_stop_ptr   (i_ig_stop_ptr),
        .i_ig_wdata_clr  (i_ig_wdata_clr),
        .i_ig_wdata_hold (i_ig_wdata_hold),
        .i_ig_wdata_en   (i_ig_wdata_en),
        .i_ig_wdata_upd  (i_ig_wdata_upd),
        .i_ig_wdata      (i_ig_wdata),
        .o_ig_empty      (o_ig_empty),
        .o_ig_full       (o_ig_full),
        .o_ig_write_done (o_ig_write_done),
        .o_ig_overflow   (o_ig_overflow),
        .o_tx_valid      (o_tx_valid),
        .o_tx_data       (o_tx_data),
        .i_tx_ready      (i_tx_ready)
    );

    always #5 i_hclk = ~i_hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_hclk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] d);
        i_ig_wdata     = d;
        i_ig_wdata_upd = 1'b1;
        tick();
        i_ig_wdata_upd = 1'b0;
        tick();
        $display("write data=%h empty=%0b full=%0b done=%0b ovf=%0b",
                 d, o_ig_empty, o_ig_full, o_ig_write_done, o_ig_overflow);
    endtask

    task automatic test_reset();
        i_hresetn       = 1'b0;
        i_ig_loop_mode  = 1'b0;
        i_ig_num_loops  = 4'd0;
        i_ig_load_ptr   = 1'b0;
        i_ig_start_ptr  = 5'd0;
        i_ig_stop_ptr   = 5'd0;
        i_ig_wdata_clr  = 1'b0;
        i_ig_wdata_hold = 1'b0;
        i_ig_wdata_en   = 1'b1;
        i_ig_wdata_upd  = 1'b0;
        i_ig_wdata      = 32'd0;
        i_tx_ready      = 1'b1;
        repeat (3) tick();
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_tx_valid); end
        checks++; if (o_tx_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", o_tx_data); end
        checks++; if (o_ig_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_ig_empty); end
        checks++; if (o_ig_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_ig_full); end
        checks++; if (o_ig_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_ig_overflow); end
        checks++; if (o_ig_write_done !== 1'b0) begin errors++; $display("FAIL reset_wdone: got %b want 0", o_ig_write_done); end
        i_hresetn = 1'b1;
        tick();
    endtask

    task automatic test_write_status();
        i_ig_stop_ptr = 5'd3;
        wr_word(32'hA0);
        checks++; if (o_ig_empty !== 1'b0) begin errors++; $display("FAIL wr_empty1: got %b want 0", o_ig_empty); end
        wr_word(32'hA1);
        wr_word(32'hA2);
        checks++; if (o_ig_write_done !== 1'b0) begin errors++; $display("FAIL wr_done_early: got %b want 0", o_ig_write_done); end
        wr_word(32'hA3);
        checks++; if (o_ig_write_done !== 1'b1) begin errors++; $display("FAIL wr_done: got %b want 1", o_ig_write_done); end
        checks++; if (o_ig_empty !== 1'b0) begin errors++; $display("FAIL wr_empty4: got %b want 0", o_ig_empty); end
        checks++; if (o_ig_full !== 1'b0) begin errors++; $display("FAIL wr_full4: got %b want 0", o_ig_full); end
    endtask

    task automatic test_single_pass();
        i_ig_start_ptr = 5'd1;
        i_ig_stop_ptr  = 5'd3;
        i_ig_loop_mode = 1'b0;
        i_tx_ready     = 1'b1;
        i_ig_load_ptr  = 1'b1;
        tick();  // load sampled: LOAD
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL sp_latency: got valid=%b want 0", o_tx_valid); end
        tick();
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 32'hA1) begin errors++; $display("FAIL sp_beat0: got v=%b d=%h want v=1 d=a1", o_tx_valid, o_tx_data); end
        $display("beat single data=%h", o_tx_data);
        tick();
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 32'hA2) begin errors++; $display("FAIL sp_beat1: got v=%b d=%h want v=1 d=a2", o_tx_valid, o_tx_data); end
        $display("beat single data=%h", o_tx_data);
        tick();
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 32'hA3) begin errors++; $display("FAIL sp_beat2: got v=%b d=%h want v=1 d=a3", o_tx_valid, o_tx_data); end
        $display("beat single data=%h", o_tx_data);
        tick();
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL sp_done: got valid=%b want 0", o_tx_valid); end
        tick();
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL sp_done_stay: got valid=%b want 0", o_tx_valid); end
        i_ig_load_ptr = 1'b0;
        tick();
    endtask

    task automatic test_loop_backpressure();
        logic [31:0] got[$];
        logic [31:0] exp_d [6];
        exp_d = '{32'hA0, 32'hA1, 32'hA0, 32'hA1, 32'hA0, 32'hA1};
        i_ig_start_ptr = 5'd0;
        i_ig_stop_ptr  = 5'd1;
        i_ig_loop_mode = 1'b1;
        i_ig_num_loops = 4'd3;
        i_ig_load_ptr  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            i_tx_ready      = ((i % 3) != 1);
            i_ig_wdata_hold = (i == 5);
            #1;
            if (o_tx_valid && i_tx_ready) begin
                got.push_back(o_tx_data);
                $display("beat loop idx=%0d data=%h", got.size() - 1, o_tx_data);
            end
        end
        i_tx_ready      = 1'b1;
        i_ig_wdata_hold = 1'b0;
        #1;
        checks++; if (got.size() != 6) begin errors++; $display("FAIL loop_count: got %0d beats want 6", got.size()); end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_d[k]) begin errors++; $display("FAIL loop_data%0d: got %h want %h", k, got[k], exp_d[k]); end
        end
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL loop_done: got valid=%b want 0", o_tx_valid); end
        i_ig_load_ptr  = 1'b0;
        i_ig_loop_mode = 1'b0;
        tick();
    endtask

    task automatic test_wrap_range();
        logic [31:0] got[$];
        logic [31:0] exp_d [4];
        exp_d = '{32'd30, 32'd31, 32'd0, 32'd1};
        i_ig_wdata_clr = 1'b1;
        tick();
        i_ig_wdata_clr = 1'b0;
        i_ig_stop_ptr  = 5'd1;
        for (int n = 0; n < 32; n++) wr_word(32'(n));
        checks++; if (o_ig_full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b want 1", o_ig_full); end
        checks++; if (o_ig_overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", o_ig_overflow); end
        i_ig_start_ptr = 5'd30;
        i_ig_loop_mode = 1'b0;
        i_ig_load_ptr  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_tx_valid && i_tx_ready) begin
                got.push_back(o_tx_data);
                $display("beat wrap idx=%0d data=%h", got.size() - 1, o_tx_data);
            end
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d beats want 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_d[k]) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", k, got[k], exp_d[k]); end
        end
        i_ig_load_ptr = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] exp0;
        logic [31:0] got[$];
`ifdef UCIE_IG_OVF_WRAP_EN
        exp0 = 32'h33;
`else
        exp0 = 32'h0;
`endif
        wr_word(32'h33);
        checks++; if (o_ig_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", o_ig_full); end
        checks++; if (o_ig_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o_ig_overflow); end
        i_ig_start_ptr = 5'd0;
        i_ig_stop_ptr  = 5'd0;
        i_ig_load_ptr  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_tx_valid && i_tx_ready) begin
                got.push_back(o_tx_data);
                $display("beat ovf data=%h", o_tx_data);
            end
        end
        checks++; if (got.size() != 1) begin errors++; $display("FAIL ovf_count: got %0d beats want 1", got.size()); end
        if (got.size() > 0) begin
            checks++; if (got[0] !== exp0) begin errors++; $display("FAIL ovf_mem0: got %h want %h", got[0], exp0); end
        end
        i_ig_load_ptr = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        i_ig_start_ptr = 5'd0;
        i_ig_stop_ptr  = 5'd1;
        i_ig_loop_mode = 1'b1;
        i_ig_num_loops = 4'd0;
        i_ig_load_ptr  = 1'b1;
        repeat (4) tick();
        checks++; if (o_tx_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", o_tx_valid); end
        checks++; if (o_ig_write_done !== 1'b1 || o_ig_overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_status: got done=%b ovf=%b want 1 1", o_ig_write_done, o_ig_overflow); end
        i_ig_wdata_clr = 1'b1;
        tick();
        $display("clear asserted valid=%b empty=%b", o_tx_valid, o_ig_empty);
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", o_tx_valid); end
        checks++; if (o_ig_empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b want 1", o_ig_empty); end
        checks++; if (o_ig_overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", o_ig_overflow); end
        checks++; if (o_ig_write_done !== 1'b0) begin errors++; $display("FAIL clr_wdone: got %b want 0", o_ig_write_done); end
        i_ig_wdata_clr = 1'b0;
        i_ig_load_ptr  = 1'b0;
        tick();
        // Load edge on an empty buffer must be ignored.
        i_ig_load_ptr = 1'b1;
        repeat (3) tick();
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL empty_load: got valid=%b want 0", o_tx_valid); end
        i_ig_load_ptr = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        i_ig_stop_ptr = 5'd1;
        wr_word(32'h11);
        wr_word(32'h22);
        i_ig_start_ptr = 5'd0;
        i_ig_loop_mode = 1'b1;
        i_ig_num_loops = 4'd0;
        i_ig_load_ptr  = 1'b1;
        tick();
        tick();
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 32'h11) begin errors++; $display("FAIL abort_pre: got v=%b d=%h want v=1 d=11", o_tx_valid, o_tx_data); end
        i_ig_load_ptr = 1'b0;
        tick();
        $display("abort valid=%b", o_tx_valid);
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", o_tx_valid); end
        tick();
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL abort_stay: got %b want 0", o_tx_valid); end
    endtask

    task automatic test_async_reset();
        i_ig_load_ptr = 1'b1;
        tick();
        tick();
        checks++; if (o_tx_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got valid=%b want 1", o_tx_valid); end
        #2;
        i_hresetn = 1'b0;
        #1;
        $display("async reset valid=%b empty=%b", o_tx_valid, o_ig_empty);
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", o_tx_valid); end
        checks++; if (o_ig_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", o_ig_empty); end
        i_ig_load_ptr = 1'b0;
        tick();
        i_hresetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_status();
        test_single_pass();
        test_loop_backpressure();
        test_wrap_range();
        test_overflow();
        test_clear();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ucie_ig_buf.md
# ucie_ig_buf

Ingress pattern buffer for the UCIe test datapath. It sits directly downstream of the UCIe CSR block and consumes its `ig_*` control fields. Software loads it one 32-bit word at a time through the CSR write-data/update mechanism. It then replays a programmed pointer range, once or in loops, as a valid/ready stream toward the TX serializer, and returns empty/full/write-done/overflow status to the CSR.

## Interface
Parameters:
- `DWIDTH`, 32, word width
- `DEPTH`, 32, buffer entries; pointers are `PTR_W = $clog2(DEPTH)` = 5 bits

Ports:
- `i_hclk`  in  1  clock
- `i_hresetn`  in  1  reset; one clock, asynchronous, active-low
- `i_ig_loop_mode`  in  1  0: single pass; 1: loop
- `i_ig_num_loops`  in  4  passes in loop mode; 0 = infinite
- `i_ig_load_ptr`  in  1  rising edge starts playback; low aborts playback
- `i_ig_start_ptr`, `i_ig_stop_ptr`  in  PTR_W  playback range, inclusive
- `i_ig_wdata_clr`  in  1  level; clears write side and playback
- `i_ig_wdata_hold`  in  1  level; gates `o_tx_valid`
- `i_ig_wdata_en`  in  1  enables writes
- `i_ig_wdata_upd`  in  1  rising edge writes `i_ig_wdata`
- `i_ig_wdata`  in  DWIDTH  word to store
- `o_ig_empty`, `o_ig_full`, `o_ig_write_done`, `o_ig_overflow`  out  1  status
- `o_tx_valid`  out  1  playback beat valid
- `o_tx_data`  out  DWIDTH  playback data
- `i_tx_ready`  in  1  downstream accept

## Operation
- **Storage:** DEPTH×DWIDTH flop array, reset to 0. Reads do not consume entries; this is a replay buffer.
- **Write side:**
  - `upd_q` registers `i_ig_wdata_upd`. A write fires when `upd && !upd_q && en`.
  - A write stores to `mem[wr_ptr]`, increments `wr_ptr` (DEPTH-1 wraps to 0), and increments `count` (saturates at DEPTH).
  - `o_ig_empty = (count==0)`; `o_ig_full = (count==DEPTH)`.
  - A write when full is dropped (see Configuration) and sets sticky `o_ig_overflow`.
  - `o_ig_write_done` is sticky; it sets when a write lands at address `i_ig_stop_ptr`.
- **Clear:** while `i_ig_wdata_clr`=1: `wr_ptr=0`, `count=0`, overflow=0, write_done=0, FSM forced to IDLE. Clear wins over a simultaneous write or load.
- **FSM:**
  - IDLE: on a `load_ptr` rising edge with `count!=0`, go to LOAD. A rising edge with `count==0` is ignored.
  - LOAD: `rd_ptr=start_ptr`, `pass_cnt=0`; go to PLAY.
  - PLAY: `o_tx_valid = !hold`; `o_tx_data = mem[rd_ptr]`. On each valid&&ready beat:
    - If `rd_ptr != stop_ptr`: `rd_ptr++`, wrapping DEPTH-1→0, so `start>stop` wraps around the buffer.
    - Else, end of a pass: `pass_cnt++`.
    - Single mode, end of pass: go to DONE.
    - Loop mode, end of pass: reload `start_ptr`, unless `num_loops!=0 && pass_cnt+1==num_loops`, in which case go to DONE.
  - PLAY with `load_ptr`=0: go to IDLE (abort).
  - DONE: valid=0. A new `load_ptr` rising edge goes to LOAD; `load_ptr`=0 goes to IDLE.
- **Hold:** hold may drop valid mid-beat. Downstream captures only on valid&&ready.
- **Write during playback:** allowed. A same-cycle write to `rd_ptr` shows the old data that cycle.
- **Stale reads:** the range may cover unwritten entries; those read as reset or stale contents.

## Timing
- Reset values: `o_tx_valid`=0, `o_tx_data`=0, `o_ig_empty`=1, `o_ig_full`=0, `o_ig_overflow`=0, `o_ig_write_done`=0. FSM=IDLE; all pointers and counters 0.
- **Write latency:** `upd` is first sampled high at edge N; memory and status update at edge N. They are visible in cycle N+1.
- **Start latency:** `load_ptr` is first sampled high at edge N; FSM=LOAD after N. `o_tx_valid`=1 after edge N+1.
- **Throughput:** one beat per cycle while ready=1 and hold=0.
- **Control sampling:** `start_ptr` is sampled in LOAD. `stop_ptr`, `loop_mode` and `num_loops` are used live; software keeps them stable during PLAY.
- **Abort/clear latency:** valid drops the cycle after `load_ptr` falls or `clr` asserts.
- **Mid-operation reset:** async reset returns everything to reset values immediately.

## Configuration
- `UCIE_IG_OVF_WRAP_EN` defined:
  - A write when full is still stored at `mem[wr_ptr]` (oldest entry overwritten).
  - `wr_ptr` advances and `count` stays DEPTH.
  - `o_ig_overflow` still sets.
- Not defined: a write when full is discarded and `mem` and `wr_ptr` are unchanged; overflow sets.

## Test plan
- **Write/status:** reset; write 0xA0..0xA3 with `stop_ptr`=3 → after the 4th write: `count`=4, empty=0, write_done=1, full=0.
- **Single pass:** `start`=1, `stop`=3, `loop_mode`=0, ready=1, `load_ptr` rise → valid two cycles later; data A1,A2,A3 on consecutive cycles; then DONE with valid=0.
- **Loop with backpressure and hold:** `start`=0, `stop`=1, `loop_mode`=1, `num_loops`=3, ready toggling, one hold pulse → exactly 6 accepted beats A0,A1,A0,A1,A0,A1; no beat lost or duplicated.
- **Wrap range:** fill 32 entries 0..31; `start`=30, `stop`=1 → beats 30,31,0,1.
- **Overflow:** 33 writes → full=1, overflow=1. Without the macro, `mem[0]` is unchanged; with `UCIE_IG_OVF_WRAP_EN`, `mem[0]` = 33rd word.
- **Clear/abort:** assert `clr` during PLAY → valid=0 next cycle; empty=1, overflow=0, write_done=0. A `load_ptr` fall mid-PLAY → IDLE, valid=0 next cycle.
